inv_cipher_fb: RTL and testbench

INV_CIPHER_FB -- requirements
Module: inv_cipher_fb

---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/inv_round_comb.sv | 37 +++
 rtl/inv_cipher_fb.sv | 111 +++++++++++
 tb/tb_inv_cipher_fb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption types, constants and GF(2^8) helpers.
package aes_pkg;

   // Byte n = 4*column + row lives in bits [8n+7:8n].
   typedef logic [127:0] aes_state_t;

   localparam int unsigned NR = 10;

   typedef enum logic [1:0] {
      StIdle,
      StInit,
      StRound,
      StFinal
   } fsm_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] v);
      return xtime(xtime(xtime(v))) ^ v;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] v);
      return xtime(xtime(xtime(v))) ^ xtime(v) ^ v;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] v);
      return xtime(xtime(xtime(v))) ^ xtime(xtime(v)) ^ v;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] v);
      return xtime(xtime(xtime(v))) ^ xtime(xtime(v)) ^ xtime(v);
   endfunction

   // General GF(2^8) product, shift-and-add.
   function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
      logic [7:0] acc;
      logic [7:0] t;
      acc = 8'h00;
      t   = p;
      for (int i = 0; i < 8; i++) begin
         if (q[i]) acc = acc ^ t;
         t = xtime(t);
      end
      return acc;
   endfunction

   // Multiplicative inverse as v^254 = product of v^(2^i) for i=1..7; maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] v);
      logic [7:0] sq;
      logic [7:0] r;
      sq = v;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   // Inverse S-box: undo the affine map, then invert in GF(2^8).
   function automatic logic [7:0] inv_sbox(input logic [7:0] v);
      logic [7:0] u;
      u = {v[6:0], v[7]} ^ {v[4:0], v[7:5]} ^ {v[1:0], v[7:2]} ^ 8'h05;
      return gf_inv(u);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] s0, s1, s2, s3;
      s0 = col[7:0];
      s1 = col[15:8];
      s2 = col[23:16];
      s3 = col[31:24];
      return {gf_mul11(s0) ^ gf_mul13(s1) ^ gf_mul9(s2)  ^ gf_mul14(s3),
              gf_mul13(s0) ^ gf_mul9(s1)  ^ gf_mul14(s2) ^ gf_mul11(s3),
              gf_mul9(s0)  ^ gf_mul14(s1) ^ gf_mul11(s2) ^ gf_mul13(s3),
              gf_mul14(s0) ^ gf_mul11(s1) ^ gf_mul13(s2) ^ gf_mul9(s3)};
   endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One combinational inverse-cipher round; MixColumns skipped on the last round.
module inv_round_comb
   import aes_pkg::*;
(
   input  aes_state_t state,
   input  aes_state_t key,
   input  logic       last_round,
   output aes_state_t next_state
);

   aes_state_t sub;
   aes_state_t ark;
   aes_state_t mixed;

   // InvShiftRows (row r rotates right by r) fused with InvSubBytes.
   always_comb begin
      sub = '0;
      for (int col = 0; col < 4; col++) begin
         for (int row = 0; row < 4; row++) begin
            sub[8*(4*col+row) +: 8] = inv_sbox(state[8*(4*((col - row + 4) % 4) + row) +: 8]);
         end
      end
   end

   assign ark = sub ^ key;

   // InvMixColumns applied column by column.
   always_comb begin
      mixed = '0;
      for (int col = 0; col < 4; col++) begin
         mixed[32*col +: 32] = inv_mix_col(ark[32*col +: 32]);
      end
   end

   assign next_state = last_round ? ark : mixed;

endmodule

// File: rtl/inv_cipher_fb.sv
// Iterative AES-128 inverse cipher, one round per accepted round key.
module inv_cipher_fb #(
   parameter int unsigned NR = aes_pkg::NR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic        key_flag,
   input  logic [31:0] k1,
   input  logic [31:0] k2,
   input  logic [31:0] k3,
   input  logic [31:0] k4,
   output logic [3:0]  round_idx,
   output logic        key_req,
   output logic        busy,
   output logic        done,
   output logic [31:0] x,
   output logic [31:0] y,
   output logic [31:0] z,
   output logic [31:0] w
);
   import aes_pkg::*;

   fsm_state_e fsm_q, fsm_d;
   aes_state_t st_q, st_d;
   aes_state_t out_q, out_d;
   aes_state_t round_key;
   aes_state_t round_out;
   logic [3:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic       last_round;

   assign round_key  = {k4, k3, k2, k1};
   assign last_round = (fsm_q == StFinal);

   inv_round_comb u_round (
      .state      (st_q),
      .key        (round_key),
      .last_round (last_round),
      .next_state (round_out)
   );

   // Next-state: each key-consuming state stalls while key_flag is low.
   always_comb begin
      fsm_d  = fsm_q;
      st_d   = st_q;
      idx_d  = idx_q;
      out_d  = out_q;
      done_d = 1'b0;
      case (fsm_q)
         StIdle: begin
            if (start) begin
               st_d  = {d, c, b, a};
               idx_d = 4'(NR);
               fsm_d = StInit;
            end
         end
         StInit: begin
            if (key_flag) begin
               st_d  = st_q ^ round_key;
               idx_d = 4'(NR - 1);
               fsm_d = StRound;
            end
         end
         StRound: begin
            if (key_flag) begin
               st_d  = round_out;
               idx_d = idx_q - 4'd1;
               if (idx_q == 4'd1) fsm_d = StFinal;
            end
         end
         StFinal: begin
            if (key_flag) begin
               st_d   = round_out;
               out_d  = round_out;
               done_d = 1'b1;
               fsm_d  = StIdle;
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q  <= StIdle;
         st_q   <= '0;
         out_q  <= '0;
         idx_q  <= 4'd0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         out_q  <= out_d;
         idx_q  <= idx_d;
         done_q <= done_d;
      end
   end

   assign round_idx    = idx_q;
   assign key_req      = (fsm_q != StIdle);
   assign busy         = key_req;
   assign done         = done_q;
   assign {w, z, y, x} = out_q;

endmodule

// File: tb/tb_inv_cipher_fb.sv
// Self-checking bench: forward-AES reference model plus a plaintext scoreboard.
module tb_inv_cipher_fb;

   logic        clk = 1'b0;
   logic        rst, start, key_flag;
   logic [31:0] a, b, c, d, k1, k2, k3, k4;
   logic [3:0]  round_idx;
   logic        key_req, busy, done;
   logic [31:0] x, y, z, w;

   always #5 clk = ~clk;

   inv_cipher_fb #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .key_flag  (key_flag),
      .k1        (k1),
      .k2        (k2),
      .k3        (k3),
      .k4        (k4),
      .round_idx (round_idx),
      .key_req   (key_req),
      .busy      (busy),
      .done      (done),
      .x         (x),
      .y         (y),
      .z         (z),
      .w         (w)
   );

   typedef struct {
      logic [127:0] pt;
      int           cyc;
   } exp_t;

   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   exp_t         sb_q[$];
   exp_t         mon_e;
   logic [127:0] held     = '0;
   logic [7:0]   sbox [256];
   logic [127:0] rk [11];

   localparam logic [127:0] C1_KEY = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
   localparam logic [127:0] C1_CT  = {32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
   localparam logic [127:0] C1_PT  = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
   localparam logic [127:0] C1_RK10 = {32'hc5302b4d, 32'h8ba707f3, 32'h174a94e3, 32'h7f1d1113};

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model (forward cipher) ----------------
   function automatic logic [7:0] tb_xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box via the generator-3 walk: p runs over 3^k, q over its inverse.
   task automatic build_sbox();
      logic [7:0] p, q, t;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         t = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = t ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] wk [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) wk[i] = key[32*i +: 32];
      for (int i = 4; i < 44; i++) begin
         t = wk[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            rc = tb_xt(rc);
         end
         wk[i] = wk[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {wk[4*r+3], wk[4*r+2], wk[4*r+1], wk[4*r]};
   endtask

   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      for (int col = 0; col < 4; col++)
         for (int row = 0; row < 4; row++)
            o[8*(4*col+row) +: 8] = sbox[s[8*(4*((col + row) % 4) + row) +: 8]];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   s0, s1, s2, s3;
      for (int col = 0; col < 4; col++) begin
         s0 = s[32*col +: 8];
         s1 = s[32*col+8 +: 8];
         s2 = s[32*col+16 +: 8];
         s3 = s[32*col+24 +: 8];
         o[32*col +: 8]    = tb_xt(s0) ^ tb_xt(s1) ^ s1 ^ s2 ^ s3;
         o[32*col+8 +: 8]  = s0 ^ tb_xt(s1) ^ tb_xt(s2) ^ s2 ^ s3;
         o[32*col+16 +: 8] = s0 ^ s1 ^ tb_xt(s2) ^ tb_xt(s3) ^ s3;
         o[32*col+24 +: 8] = tb_xt(s0) ^ s0 ^ s1 ^ s2 ^ tb_xt(s3);
      end
      return o;
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r < 10; r++) s = mix_cols(sub_shift(s)) ^ rk[r];
      return sub_shift(s) ^ rk[10];
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", done, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               check("plaintext", {w, z, y, x}, mon_e.pt);
               check("done_cycle", cyc, mon_e.cyc);
               held = mon_e.pt;
            end
         end else begin
            check("output_hold", {w, z, y, x}, held);
         end
      end
   end

   // ---------------- driver ----------------
   // Called at posedge+1 with the DUT idle; returns at posedge+1 of the done cycle.
   task automatic run_op(input logic [127:0] ct, input logic [127:0] pt, input int gap,
                         input int start_at, input int abort_after);
      exp_t e;
      int   exp_idx;
      e.pt  = pt;
      e.cyc = cyc + 12 + 10 * gap;
      sb_q.push_back(e);
      {d, c, b, a} = ct;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {busy, key_req}, 2'b11);
      exp_idx = 10;
      for (int k = 0; k < 11; k++) begin
         if (k == abort_after) begin
            rst = 1'b1;
            #1;
            sb_q.delete();
            held = '0;
            check("rst_round_idx", round_idx, 4'd0);
            check("rst_flags", {key_req, busy, done}, 3'b000);
            check("rst_outputs", {w, z, y, x}, 128'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check("idle_after_rst", {busy, round_idx}, 5'd0);
            return;
         end
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               key_flag = 1'b0;
               check("idx_stall", round_idx, exp_idx);
               @(posedge clk); #1;
            end
         end
         if (k == start_at) begin
            start = 1'b1;
            {d, c, b, a} = ~ct;
         end
         key_flag = 1'b1;
         {k4, k3, k2, k1} = rk[exp_idx];
         check("round_idx", round_idx, exp_idx);
         check("busy", {busy, key_req}, 2'b11);
         @(posedge clk); #1;
         start = 1'b0;
         if (exp_idx > 0) exp_idx--;
      end
      key_flag = 1'b0;
      check("done_pulse", done, 1'b1);
      check("busy_at_done", busy, 1'b0);
   endtask

   task automatic idle_key_pulse();
      key_flag = 1'b1;
      {k4, k3, k2, k1} = rk[3];
      repeat (2) begin
         @(posedge clk); #1;
      end
      key_flag = 1'b0;
      check("idle_kf_idx", round_idx, 4'd0);
      check("idle_kf_busy", busy, 1'b0);
   endtask

   initial begin
      logic [127:0] pt;
      rst = 1'b1;
      start = 1'b0;
      key_flag = 1'b0;
      {a, b, c, d, k1, k2, k3, k4} = '0;
      build_sbox();
      expand_key(C1_KEY);
      check("model_rk10", rk[10], C1_RK10);
      check("model_enc", encrypt(C1_PT), C1_CT);
      #1;
      check("reset_idx", round_idx, 4'd0);
      check("reset_flags", {key_req, busy, done}, 3'b000);
      check("reset_outputs", {w, z, y, x}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", busy, 1'b0);

      // key_flag in IDLE must be ignored
      idle_key_pulse();
      // plain C.1
      run_op(C1_CT, C1_PT, 0, -1, -1);
      repeat (2) begin @(posedge clk); #1; end
      // C.1 with 3-cycle stalls between keys
      run_op(C1_CT, C1_PT, 3, -1, -1);
      repeat (2) begin @(posedge clk); #1; end
      // start pulsed while busy, then key_flag in IDLE
      run_op(C1_CT, C1_PT, 0, 4, -1);
      idle_key_pulse();
      // reset after the 5th key, then a fresh C.1 run
      run_op(encrypt(rand128()), C1_PT, 0, -1, 5);
      run_op(C1_CT, C1_PT, 0, -1, -1);
      // back-to-back: next start in each done cycle
      pt = rand128();
      run_op(encrypt(pt), pt, 0, -1, -1);
      pt = rand128();
      run_op(encrypt(pt), pt, 1, -1, -1);
      // a few random blocks with random stalls
      for (int i = 0; i < 3; i++) begin
         pt = rand128();
         run_op(encrypt(pt), pt, int'($urandom_range(0, 2)), -1, -1);
      end
      repeat (3) begin @(posedge clk); #1; end
      check("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
